tinyalu_param: RTL and testbench
================================

# tinyalu_param

- Parametrised successor to the fixed 8-bit TinyALU datapath, shared across the BFM/UVM testbench as the DUT model.
- Takes two `WIDTH`-bit operands and a 3-bit opcode under a start/done handshake.
- Executes single-cycle operations (add, and, xor, reset-result) and a multi-cycle unsigned multiply.
- Returns a `2*WIDTH`-bit result.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; minimum 2.
- `MULT_CYCLES`, default 3: multiply latency in cycles; minimum 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `A`  in  `WIDTH`  operand A, sampled on the start edge.
- `B`  in  `WIDTH`  operand B, sampled on the start edge.
- `op`  in  3  opcode:
  - 000 nop
  - 001 add
  - 010 and
  - 011 xor
  - 100 mult
  - 101 rst
  - 110 sub (only with macro)
  - 111 nop
- `start`  in  1  request; sampled only in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a multiply is in progress, before its DONE cycle.
- `result`  out  `2*WIDTH`  registered result; held between completions.

## Operation
- FSM states: IDLE, MULT, DONE.
  - IDLE with `start`=1 and op ∈ {add, and, xor, rst, sub*} → DONE.
  - IDLE with `start`=1 and op = mult → MULT (counter loaded); goes straight to DONE if `MULT_CYCLES`=1.
  - IDLE with `start`=0, or with op = nop / 111 / 110 (macro undefined) → stay in IDLE; no `done`, `result` unchanged.
  - MULT → DONE when the counter expires, after `MULT_CYCLES`-1 cycles in MULT.
  - DONE → IDLE unconditionally.
- `A`, `B` and `op` are captured into internal registers on the start edge. Changes to these inputs while in MULT or DONE have no effect.
- `start` is ignored in MULT and DONE, so no re-trigger occurs while busy.
- A `start` held high re-issues the operation once the FSM is back in IDLE.
- Arithmetic rules (all unsigned; unused upper `result` bits are zero):
  - add: `result[WIDTH:0]` = A + B, with carry out in bit `WIDTH`.
  - and: zero-extended A & B.
  - xor: zero-extended A ^ B.
  - mult: full `2*WIDTH`-bit product A*B.
  - rst: `result` = 0, and `done` still pulses.
- `result` and `done` are written on the same edge. `result` holds its value until the next completing operation or `reset`.
- `reset`:
  - Takes priority over `start` and over every state.
  - On any edge with `reset`=1: state → IDLE, `done`=0, `busy`=0, `result`=0, counter=0.
  - An operation in flight is discarded; no late `done` follows.

## Timing
- Cycle 0 is the cycle whose ending edge samples `start`=1 in IDLE.
- Latency L is 1 for single-cycle ops and `MULT_CYCLES` for mult.
- `done`=1 exactly in cycle L; `result` is valid from cycle L onward.
- `busy`=1 in cycles 1..L-1, so it is never asserted for single-cycle ops.
- With `start` held continuously high, the next sample edge is at the end of cycle L+1 and the next `done` comes at cycle 2L+1. Back-to-back throughput is one operation per L+1 cycles.
- Reset values: `done`=0, `busy`=0, `result`=0.

## Configuration
- `TINYALU_SUB_EN` defined:
  - op 110 = sub: `result[WIDTH:0]` = ({1'b0,A} − {1'b0,B}) mod 2^(WIDTH+1).
  - Bit `WIDTH` is the borrow; latency 1.
- Undefined: op 110 is a nop (no `done`, `result` held), and no subtract logic is synthesised.

## Test plan
Conditions: `WIDTH`=8, `MULT_CYCLES`=3.
- add A=0xFF, B=0x01, `start` pulse → `done` in cycle 1, `result`=0x0100, `busy` stays 0.
- mult A=0xFF, B=0xFF; A driven to 0x00 in cycle 1 → `busy` high in cycles 1–2, `done` in cycle 3, `result`=0xFE01.
- and 0xF0 & 0x3C → 0x0030, then xor 0xF0 ^ 0x3C → 0x00CC, each with `done` one cycle after its start.
- rst with `result`=0x00CC → `result`=0x0000 and `done` in cycle 1. nop with `start`=1 for 5 cycles → no `done`, `result` unchanged.
- mult in progress, `reset`=1 sampled in cycle 2 → cycle 3 shows `busy`=0, `done`=0, `result`=0; no `done` follows.
- Macro defined: op 110 with A=0x05, B=0x07 → `result`=0x01FE in cycle 1. Macro undefined: same stimulus → no `done`, `result` held.

Source files
------------

// File: rtl/tinyalu_param.sv
// tinyalu_param: parametrised TinyALU datapath with a start/done handshake.
// Single-cycle ops (add, and, xor, rst) and a MULT_CYCLES-latency unsigned multiply.
// Optional feature: define TINYALU_SUB_EN to enable op 110 as a subtract with borrow.
// Without the macro op 110 behaves as a nop and no subtract logic exists.
module tinyalu_param #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MULT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result
);

    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpXor = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpRst = 3'b101;
`ifdef TINYALU_SUB_EN
    localparam logic [2:0] OpSub = 3'b110;
`endif

    // Counter holds the number of MULT cycles still to go after the current one.
    localparam int unsigned CntW = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES - 1) : 1;
    localparam int unsigned CntLoadInt = (MULT_CYCLES >= 2) ? (MULT_CYCLES - 2) : 0;
    localparam logic [CntW-1:0] CntLoad = CntW'(CntLoadInt);

    typedef enum logic [1:0] {StIdle, StMult, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2:0]           op_q, op_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic start_single;
    logic start_mult;

    // Compute the result of an operation; unused upper bits stay zero.
    function automatic logic [2*WIDTH-1:0] alu_f(input logic [2:0]       opc,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] r;
        r = '0;
        case (opc)
            OpAdd:   r[WIDTH:0] = {1'b0, a} + {1'b0, b};
            OpAnd:   r[WIDTH-1:0] = a & b;
            OpXor:   r[WIDTH-1:0] = a ^ b;
            OpMul:   r = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`ifdef TINYALU_SUB_EN
            OpSub:   r[WIDTH:0] = {1'b0, a} - {1'b0, b};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // Opcodes that complete in a single cycle.
    function automatic logic is_single_f(input logic [2:0] opc);
        logic s;
        s = (opc == OpAdd) || (opc == OpAnd) || (opc == OpXor) || (opc == OpRst);
`ifdef TINYALU_SUB_EN
        s = s || (opc == OpSub);
`endif
        return s;
    endfunction

    assign start_single = start && is_single_f(op);
    assign start_mult   = start && (op == OpMul);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_single) begin
                    state_d = StDone;
                end else if (start_mult) begin
                    state_d = (MULT_CYCLES == 1) ? StDone : StMult;
                end
            end
            StMult: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        done = 1'b0;
        busy = 1'b0;
        case (state_q)
            StMult:  busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, multiply counter and result update.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (start_single || start_mult) begin
                    a_d   = A;
                    b_d   = B;
                    op_d  = op;
                    cnt_d = CntLoad;
                end
                // Single-cycle results (and a 1-cycle multiply) land on the start edge.
                if (start_single || (start_mult && (MULT_CYCLES == 1))) begin
                    result_d = alu_f(op, A, B);
                end
            end
            StMult: begin
                if (cnt_q == '0) begin
                    result_d = alu_f(op_q, a_q, b_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_tinyalu_param.sv
// Directed self-checking bench for tinyalu_param (WIDTH=8, MULT_CYCLES=3).
module tb_tinyalu_param;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               reset;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               done;
    logic               busy;
    logic [2*WIDTH-1:0] result;

    int n_tests;
    int n_fail;

    tinyalu_param #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .busy   (busy),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        A       = '0;
        B       = '0;
        op      = '0;
        start   = 1'b0;
        tick();
        tick();
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_result", 32'(result), 32'h0);
        reset = 1'b0;
        tick();

        // add with carry out
        issue(3'b001, 8'hFF, 8'h01);
        tick();
        start = 1'b0;
        check_eq("add_done", 32'(done), 32'd1);
        check_eq("add_busy", 32'(busy), 32'd0);
        check_eq("add_result", 32'(result), 32'h0100);
        tick();
        check_eq("add_done_c2", 32'(done), 32'd0);
        check_eq("add_hold", 32'(result), 32'h0100);

        // multiply; operand A changed mid-flight must not matter
        issue(3'b100, 8'hFF, 8'hFF);
        tick();
        start = 1'b0;
        A     = 8'h00;
        check_eq("mul_busy_c1", 32'(busy), 32'd1);
        check_eq("mul_done_c1", 32'(done), 32'd0);
        tick();
        check_eq("mul_busy_c2", 32'(busy), 32'd1);
        check_eq("mul_done_c2", 32'(done), 32'd0);
        tick();
        check_eq("mul_done_c3", 32'(done), 32'd1);
        check_eq("mul_busy_c3", 32'(busy), 32'd0);
        check_eq("mul_result", 32'(result), 32'hFE01);
        tick();
        check_eq("mul_done_c4", 32'(done), 32'd0);

        // and, then xor
        issue(3'b010, 8'hF0, 8'h3C);
        tick();
        start = 1'b0;
        check_eq("and_done", 32'(done), 32'd1);
        check_eq("and_result", 32'(result), 32'h0030);
        tick();
        issue(3'b011, 8'hF0, 8'h3C);
        tick();
        start = 1'b0;
        check_eq("xor_done", 32'(done), 32'd1);
        check_eq("xor_result", 32'(result), 32'h00CC);
        tick();

        // rst op clears result and still pulses done
        issue(3'b101, 8'h12, 8'h34);
        tick();
        start = 1'b0;
        check_eq("rstop_done", 32'(done), 32'd1);
        check_eq("rstop_result", 32'(result), 32'h0000);
        tick();

        // non-zero result so holding can be observed
        issue(3'b001, 8'h12, 8'h34);
        tick();
        start = 1'b0;
        check_eq("add2_result", 32'(result), 32'h0046);
        tick();

        // nop (000 and 111) held for 5 cycles each
        issue(3'b000, 8'hAA, 8'h55);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("nop0_done", 32'(done), 32'd0);
        end
        op = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("nop7_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        check_eq("nop_hold", 32'(result), 32'h0046);

        // op 110
        issue(3'b110, 8'h05, 8'h07);
`ifdef TINYALU_SUB_EN
        tick();
        start = 1'b0;
        check_eq("sub_done", 32'(done), 32'd1);
        check_eq("sub_result", 32'(result), 32'h01FE);
        tick();
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("op6_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        check_eq("op6_hold", 32'(result), 32'h0046);
        tick();
`endif

        // start held high: done in cycles 1 and 3 (L=1)
        issue(3'b001, 8'h01, 8'h02);
        tick();
        check_eq("b2b_done_c1", 32'(done), 32'd1);
        check_eq("b2b_result", 32'(result), 32'h0003);
        tick();
        check_eq("b2b_done_c2", 32'(done), 32'd0);
        A = 8'h10;
        tick();
        start = 1'b0;
        check_eq("b2b_done_c3", 32'(done), 32'd1);
        check_eq("b2b_result2", 32'(result), 32'h0012);
        tick();

        // reset sampled during cycle 2 of a multiply
        issue(3'b100, 8'h03, 8'h04);
        tick();
        start = 1'b0;
        tick();
        check_eq("mrst_busy_c2", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_result", 32'(result), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("mrst_no_late_done", 32'(done), 32'd0);
        end
        check_eq("mrst_result_end", 32'(result), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
